// File: rtl/pixel_tx_pkg.sv
// Shared types for the pixel byte transmit stage.
// Channel ordering and FSM state encoding.
package pixel_tx_pkg;

    localparam int PIXEL_CH_W = 8;
    localparam int CH_FIRST   = 2;
    localparam int CH_LAST    = 0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CH2,
        S_CH1,
        S_CH0
    } tx_state_t;

    typedef logic [2:0][PIXEL_CH_W-1:0] pixel_t;

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO with extra-bit pointers for full/empty.
// Head word is presented on dout; the consumer registers it.
module pixel_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    assign count   = wptr - rptr;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (wptr == rptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rptr[AW-1:0]];

    // Storage array; written only on an accepted push.
    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem[wptr[AW-1:0]] <= din;
        end
    end

    // Pointer advance on accepted push and pop.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

endmodule

// File: rtl/pixel_byte_tx.sv
// Buffers RGB pixels and serialises them as channel bytes
// (ch2, ch1, ch0) on a valid/ready stream with frame tracking.
module pixel_byte_tx
    import pixel_tx_pkg::*;
#(
    parameter int COLOR_CHANNEL = 8,
    parameter int FIFO_DEPTH    = 16,
    parameter int IMG_WIDTH     = 640,
    parameter int IMG_HEIGHT    = 480
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    input  logic                          i_data_ready,
    input  logic [2:0][COLOR_CHANNEL-1:0] i_data,
    input  logic                          i_frame_start,
    output logic                          o_tx_valid,
    output logic [COLOR_CHANNEL-1:0]      o_tx_data,
    input  logic                          i_tx_ready,
    output logic                          o_frame_done,
    output logic                          o_overflow,
    output logic                          o_busy
);

    localparam int PW        = 3 * COLOR_CHANNEL;
    localparam int AW        = $clog2(FIFO_DEPTH);
    localparam int FRAME_PIX = IMG_WIDTH * IMG_HEIGHT;
    localparam int CW        = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_PIX - 1);

    tx_state_t                     state;
    logic [2:0][COLOR_CHANNEL-1:0] r_pix;
    logic [2:0][COLOR_CHANNEL-1:0] fifo_dout;
    logic [CW-1:0]                 r_cnt;
    logic [AW:0]                   fifo_count;
    logic                          fifo_full;
    logic                          fifo_empty;
    logic                          push;
    logic                          pop;
    logic                          ch0_hs;

    assign push   = i_data_ready && !fifo_full;
    assign ch0_hs = (state == S_CH0) && i_tx_ready;
    assign pop    = !fifo_empty && ((state == S_IDLE) || ch0_hs);
    assign o_busy = (fifo_count != '0) || (state != S_IDLE);

    pixel_fifo #(
        .WIDTH (PW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .push      (push),
        .pop       (pop),
        .din       (i_data),
        .dout      (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Byte serialiser: loads a pixel, then steps ch2 -> ch1 -> ch0.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state      <= S_IDLE;
            r_pix      <= '0;
            o_tx_valid <= 1'b0;
            o_tx_data  <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (pop) begin
                        r_pix      <= fifo_dout;
                        o_tx_data  <= fifo_dout[CH_FIRST];
                        o_tx_valid <= 1'b1;
                        state      <= S_CH2;
                    end
                end
                S_CH2: begin
                    if (i_tx_ready) begin
                        o_tx_data <= r_pix[1];
                        state     <= S_CH1;
                    end
                end
                S_CH1: begin
                    if (i_tx_ready) begin
                        o_tx_data <= r_pix[CH_LAST];
                        state     <= S_CH0;
                    end
                end
                S_CH0: begin
                    if (i_tx_ready) begin
                        if (pop) begin
                            r_pix     <= fifo_dout;
                            o_tx_data <= fifo_dout[CH_FIRST];
                            state     <= S_CH2;
                        end else begin
                            o_tx_valid <= 1'b0;
                            state      <= S_IDLE;
                        end
                    end
                end
                default: begin
                    o_tx_valid <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

    // Pixel-in-frame counter; frame start clears, last pixel wraps.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_cnt <= '0;
        end else if (i_frame_start) begin
            r_cnt <= '0;
        end else if (ch0_hs) begin
            if (r_cnt == LAST_IDX) r_cnt <= '0;
            else                   r_cnt <= r_cnt + 1'b1;
        end
    end

    // One-cycle frame-done pulse after the frame's final byte.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_frame_done <= 1'b0;
        end else begin
            o_frame_done <= ch0_hs && (r_cnt == LAST_IDX);
        end
    end

    // Sticky drop flag; a frame start takes priority over a drop.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_overflow <= 1'b0;
        end else if (i_frame_start) begin
            o_overflow <= 1'b0;
        end else if (i_data_ready && fifo_full) begin
            o_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pixel_byte_tx.sv
// Directed bench for pixel_byte_tx (FIFO_DEPTH=4, 2x2 frame).
// Expected values are hand-computed per scenario.
module tb_pixel_byte_tx;

    logic            clk;
    logic            rst_n;
    logic            data_ready;
    logic [2:0][7:0] data;
    logic            frame_start;
    logic            tx_valid;
    logic [7:0]      tx_data;
    logic            tx_ready;
    logic            frame_done;
    logic            overflow;
    logic            busy;

    int n_checks;
    int n_pass;

    pixel_byte_tx #(
        .COLOR_CHANNEL (8),
        .FIFO_DEPTH    (4),
        .IMG_WIDTH     (2),
        .IMG_HEIGHT    (2)
    ) dut (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .i_data_ready  (data_ready),
        .i_data        (data),
        .i_frame_start (frame_start),
        .o_tx_valid    (tx_valid),
        .o_tx_data     (tx_data),
        .i_tx_ready    (tx_ready),
        .o_frame_done  (frame_done),
        .o_overflow    (overflow),
        .o_busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        data_ready  = 1'b0;
        data        = '0;
        frame_start = 1'b0;
        tx_ready    = 1'b0;
        step();
        step();
        n_checks++;
        if ({tx_valid, tx_data, frame_done, overflow, busy} !== 12'h0)
            $display("FAIL reset_outputs: got v=%0b d=%h fd=%0b ov=%0b b=%0b, want all 0",
                     tx_valid, tx_data, frame_done, overflow, busy);
        else n_pass++;
        rst_n = 1'b1;
        step();
        step();
        n_checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL reset_release: got v=%0b b=%0b, want 0 0", tx_valid, busy);
        else n_pass++;
    endtask

    task automatic test_single();
        logic [7:0] exp_b [3];
        exp_b = '{8'hAA, 8'h55, 8'h0F};
        tx_ready   = 1'b1;
        data       = {8'hAA, 8'h55, 8'h0F};
        data_ready = 1'b1;
        step();
        data_ready = 1'b0;
        n_checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b1)
            $display("FAIL single_n1: got v=%0b b=%0b, want v=0 b=1", tx_valid, busy);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (tx_valid !== 1'b1 || tx_data !== exp_b[i])
                $display("FAIL single_byte%0d: got v=%0b d=%h, want v=1 d=%h",
                         i, tx_valid, tx_data, exp_b[i]);
            else n_pass++;
        end
        step();
        n_checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL single_done: got v=%0b b=%0b, want 0 0", tx_valid, busy);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b [6];
        exp_b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        tx_ready   = 1'b1;
        data       = {8'h01, 8'h02, 8'h03};
        data_ready = 1'b1;
        step();
        data       = {8'h04, 8'h05, 8'h06};
        step();
        data_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (tx_valid !== 1'b1 || tx_data !== exp_b[i])
                $display("FAIL b2b_byte%0d: got v=%0b d=%h, want v=1 d=%h",
                         i, tx_valid, tx_data, exp_b[i]);
            else n_pass++;
            step();
        end
        n_checks++;
        if (tx_valid !== 1'b0)
            $display("FAIL b2b_end: got v=%0b, want 0", tx_valid);
        else n_pass++;
    endtask

    task automatic test_stall();
        tx_ready   = 1'b1;
        data       = {8'h11, 8'h22, 8'h33};
        data_ready = 1'b1;
        step();
        data_ready = 1'b0;
        step();
        n_checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h11)
            $display("FAIL stall_ch2: got v=%0b d=%h, want 1 11", tx_valid, tx_data);
        else n_pass++;
        step();
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if (tx_valid !== 1'b1 || tx_data !== 8'h22)
                $display("FAIL stall_hold%0d: got v=%0b d=%h, want 1 22",
                         i, tx_valid, tx_data);
            else n_pass++;
        end
        tx_ready = 1'b1;
        step();
        n_checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h33)
            $display("FAIL stall_resume: got v=%0b d=%h, want 1 33", tx_valid, tx_data);
        else n_pass++;
        step();
        n_checks++;
        if (tx_valid !== 1'b0)
            $display("FAIL stall_end: got v=%0b, want 0", tx_valid);
        else n_pass++;
    endtask

    task automatic test_overflow();
        logic [7:0] exp_b [$];
        int idx;
        tx_ready   = 1'b0;
        data       = {8'hA1, 8'hA2, 8'hA3};
        data_ready = 1'b1;
        step();
        data_ready = 1'b0;
        step();
        n_checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'hA1)
            $display("FAIL ovf_hold: got v=%0b d=%h, want 1 a1", tx_valid, tx_data);
        else n_pass++;
        exp_b = '{8'hA1, 8'hA2, 8'hA3};
        for (int k = 0; k < 6; k++) begin
            if (k == 4) begin
                n_checks++;
                if (overflow !== 1'b0)
                    $display("FAIL ovf_early: got %0b, want 0", overflow);
                else n_pass++;
            end
            if (k == 5) begin
                n_checks++;
                if (overflow !== 1'b1)
                    $display("FAIL ovf_set: got %0b, want 1", overflow);
                else n_pass++;
            end
            data = {8'((k+1)*16), 8'((k+1)*16+1), 8'((k+1)*16+2)};
            if (k < 4) begin
                exp_b.push_back(8'((k+1)*16));
                exp_b.push_back(8'((k+1)*16+1));
                exp_b.push_back(8'((k+1)*16+2));
            end
            data_ready = 1'b1;
            step();
        end
        data_ready = 1'b0;
        tx_ready   = 1'b1;
        idx = 0;
        for (int c = 0; c < 40; c++) begin
            if (tx_valid && tx_ready) begin
                n_checks++;
                if (idx >= 15 || tx_data !== exp_b[idx])
                    $display("FAIL ovf_byte%0d: got %h, want %h",
                             idx, tx_data, (idx < 15) ? exp_b[idx] : 8'h00);
                else n_pass++;
                idx++;
            end
            step();
        end
        n_checks++;
        if (idx != 15)
            $display("FAIL ovf_count: got %0d bytes, want 15", idx);
        else n_pass++;
        n_checks++;
        if (overflow !== 1'b1 || busy !== 1'b0)
            $display("FAIL ovf_sticky: got ov=%0b b=%0b, want 1 0", overflow, busy);
        else n_pass++;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        n_checks++;
        if (overflow !== 1'b0)
            $display("FAIL ovf_clear: got %0b, want 0", overflow);
        else n_pass++;
    endtask

    task automatic test_frame();
        logic [7:0] exp_b [$];
        int hs, hs12, pulses, pulse_cyc;
        tx_ready    = 1'b1;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            exp_b.push_back(8'hC0 + 8'(k));
            exp_b.push_back(8'hD0 + 8'(k));
            exp_b.push_back(8'hE0 + 8'(k));
        end
        hs = 0; hs12 = -10; pulses = 0; pulse_cyc = -1;
        for (int c = 0; c < 60; c++) begin
            if (frame_done === 1'b1) begin
                pulses++;
                pulse_cyc = c;
            end
            if (tx_valid && tx_ready) begin
                n_checks++;
                if (hs >= 15 || tx_data !== exp_b[hs])
                    $display("FAIL frame_byte%0d: got %h, want %h",
                             hs, tx_data, (hs < 15) ? exp_b[hs] : 8'h00);
                else n_pass++;
                hs++;
                if (hs == 12) hs12 = c;
            end
            if (c < 5) begin
                data       = {8'hC0 + 8'(c), 8'hD0 + 8'(c), 8'hE0 + 8'(c)};
                data_ready = 1'b1;
            end else begin
                data_ready = 1'b0;
            end
            step();
        end
        n_checks++;
        if (pulses != 1)
            $display("FAIL frame_pulses: got %0d, want 1", pulses);
        else n_pass++;
        n_checks++;
        if (pulse_cyc != hs12 + 1)
            $display("FAIL frame_pulse_pos: got cycle %0d, want %0d", pulse_cyc, hs12 + 1);
        else n_pass++;
        n_checks++;
        if (dut.r_cnt !== 2'd1)
            $display("FAIL frame_cnt: got %0d, want 1", dut.r_cnt);
        else n_pass++;
        n_checks++;
        if (overflow !== 1'b0)
            $display("FAIL frame_no_ovf: got %0b, want 0", overflow);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int seen_v, seen_d;
        tx_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            data       = {8'h70 + 8'(k), 8'h80 + 8'(k), 8'h90 + 8'(k)};
            data_ready = 1'b1;
            step();
        end
        data_ready = 1'b0;
        tx_ready   = 1'b1;
        step();
        tx_ready = 1'b0;
        n_checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h80 || busy !== 1'b1)
            $display("FAIL rmid_ch1: got v=%0b d=%h b=%0b, want 1 80 1",
                     tx_valid, tx_data, busy);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({tx_valid, tx_data, frame_done, overflow, busy} !== 12'h0)
            $display("FAIL rmid_async: got v=%0b d=%h fd=%0b ov=%0b b=%0b, want all 0",
                     tx_valid, tx_data, frame_done, overflow, busy);
        else n_pass++;
        step();
        step();
        rst_n    = 1'b1;
        tx_ready = 1'b1;
        seen_v = 0;
        seen_d = 0;
        for (int c = 0; c < 20; c++) begin
            if (tx_valid !== 1'b0) seen_v++;
            if (frame_done !== 1'b0) seen_d++;
            step();
        end
        n_checks++;
        if (seen_v != 0 || seen_d != 0)
            $display("FAIL rmid_quiet: got valid=%0d done=%0d cycles, want 0 0",
                     seen_v, seen_d);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0)
            $display("FAIL rmid_busy: got %0b, want 0", busy);
        else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_overflow();
        test_frame();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pixel_byte_tx.md
Name: pixel_byte_tx

Overview:
- Stage directly downstream of the post-processing stage.
- Accepts one RGB pixel per cycle on a data-ready strobe and buffers it in a small FIFO.
- Serialises each pixel into three channel bytes (channel 2, then 1, then 0) over a valid/ready byte stream, which feeds the UART/host TX path.
- Counts pixels per frame, pulses frame-done after the last byte of the frame, and flags dropped pixels.

Parameters:
COLOR_CHANNEL, 8, bits per colour channel; also the width of the output byte.
FIFO_DEPTH, 16, pixel FIFO entries; must be a power of two and at least 2.
IMG_WIDTH, 640, pixels per line.
IMG_HEIGHT, 480, lines per frame.

Ports:
i_clk  in  1  clock
i_reset_n  in  1  asynchronous active-low reset
i_data_ready  in  1  pixel strobe; i_data is valid this cycle
i_data  in  [2:0][COLOR_CHANNEL-1:0]  pixel; index 2 is sent first
i_frame_start  in  1  single-cycle pulse; clears frame counter and overflow flag
o_tx_valid  out  1  o_tx_data holds a byte
o_tx_data  out  COLOR_CHANNEL  output byte
i_tx_ready  in  1  sink accepts the byte when o_tx_valid and i_tx_ready are both 1
o_frame_done  out  1  one-cycle pulse after the last byte of the frame is accepted
o_overflow  out  1  sticky; at least one pixel was dropped
o_busy  out  1  FIFO not empty or FSM not idle

Behaviour:
- Clock and reset: i_clk; i_reset_n is asynchronous, active-low.
- Reset:
  - FIFO empty; FSM in S_IDLE; pixel counter 0.
  - o_tx_valid=0, o_tx_data=0, o_frame_done=0, o_overflow=0, o_busy=0.
  - Reset mid-frame discards all buffered and in-flight data; no frame-done is produced.
- FIFO write:
  - Push when i_data_ready=1 and the FIFO is not full, based on the count at the start of that cycle.
  - A pop in the same cycle does not free space for that push.
  - i_data_ready=1 while full: pixel dropped, o_overflow set to 1 from the next cycle.
- FIFO read: registered. The count updates on the cycle after a push; the popped word is available in the holding register on the cycle after the pop.
- FSM states: S_IDLE, S_CH2, S_CH1, S_CH0.
  - S_IDLE: if FIFO not empty, pop into r_pix and go to S_CH2. Otherwise stay.
  - S_CHk: o_tx_valid=1, o_tx_data=r_pix[k]. Hold the state and data stable until i_tx_ready=1.
    - On handshake, S_CH2 goes to S_CH1 and S_CH1 goes to S_CH0.
  - S_CH0 handshake:
    - If FIFO not empty, pop and go to S_CH2 with no bubble; the next pixel's ch2 byte appears on the next cycle.
    - Otherwise go to S_IDLE.
- Latency: a pixel strobed at cycle N into an idle, empty block gives o_tx_valid=1 with ch2 at cycle N+2.
- Throughput: with i_tx_ready held high, at most one pixel per 3 cycles.
- Frame counter:
  - Width is clog2(IMG_WIDTH*IMG_HEIGHT).
  - Increments on each S_CH0 handshake.
  - When the count equals IMG_WIDTH*IMG_HEIGHT-1 at the S_CH0 handshake: o_frame_done=1 on the next cycle (one cycle only) and the counter wraps to 0.
- i_frame_start:
  - Clears the counter and o_overflow on the next edge.
  - Does not flush the FIFO or abort the current pixel.
  - If it coincides with the final-pixel S_CH0 handshake, o_frame_done still pulses and the counter ends at 0.
  - If it coincides with an overflowing push, clear wins; the drop is not flagged.
- Outside S_CHk, o_tx_data holds its last value and o_tx_valid=0.
- o_busy is combinational: (FIFO count != 0) || (state != S_IDLE).

Decomposition:
- Package pixel_tx_pkg:
  - tx_state_t enum (S_IDLE, S_CH2, S_CH1, S_CH0).
  - pixel_t typedef ([2:0][COLOR_CHANNEL-1:0]).
  - CH_FIRST=2 and CH_LAST=0 constants.
- Sub-module pixel_fifo:
  - Synchronous FIFO parameterised on width and depth; ports push, pop, din, dout, full, empty, count.
  - Read pointer and write pointer carry one extra bit for full/empty detection.
  - Reusable by other stream stages.

Test Plan:
- Reset, then one pixel {8'hAA,8'h55,8'h0F} at cycle 5, i_tx_ready=1 -> bytes AA, 55, 0F on cycles 7, 8, 9; o_busy low from cycle 10.
- Back-to-back pixels P0={01,02,03} and P1={04,05,06} with i_tx_ready=1 -> 01 02 03 04 05 06 on six consecutive valid cycles with no gap.
- i_tx_ready=0 for 5 cycles while in S_CH1 -> o_tx_data stays at byte 1 and o_tx_valid stays 1; the sequence resumes unchanged when ready returns.
- FIFO_DEPTH=4, i_tx_ready=0, six pixels strobed -> four buffered, o_overflow=1, later output is exactly the first four pixels. A following i_frame_start clears o_overflow.
- IMG_WIDTH=2, IMG_HEIGHT=2, five pixels sent -> o_frame_done pulses once, the cycle after the 12th byte handshake; the counter then reads 1 after the 5th pixel.
- Assert i_reset_n=0 mid-S_CH1 with 3 pixels queued -> all outputs 0 immediately; after release no bytes are sent and no frame-done pulse occurs.
